// File: rtl/mult_booth.sv
// Sequential signed WIDTHxWIDTH multiplier using radix-2 Booth recoding,
// one recoding step per clock, with the product held in Hi/Lo.
module mult_booth #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] Multiplicando,
  input  logic [WIDTH-1:0] Multiplicador,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   m_q, m_d;
  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q1_q, q1_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   a_sh;
  logic [WIDTH-1:0] q_sh;

  // The extra accumulator bit keeps A-M exact when M is the most negative value.
  always_comb begin
    unique case ({q_q[0], q1_q})
      2'b01:   sum = a_q + m_q;
      2'b10:   sum = a_q - m_q;
      default: sum = a_q;
    endcase
    a_sh = {sum[WIDTH], sum[WIDTH:1]};
    q_sh = {sum[0], q_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          m_d     = {Multiplicando[WIDTH-1], Multiplicando};
          a_d     = '0;
          q_d     = Multiplicador;
          q1_d    = 1'b0;
          cnt_d   = CW'(WIDTH);
          busy_d  = 1'b1;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = a_sh;
        q_d   = q_sh;
        q1_d  = q_q[0];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          hi_d    = a_sh[WIDTH-1:0];
          lo_d    = q_sh;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;

endmodule

// File: tb/tb_mult_booth.sv
// Self-checking bench for mult_booth: a countdown/product reference model is
// compared every cycle, plus hand-computed literal results for directed cases.
module tb_mult_booth;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] Multiplicando;
  logic [WIDTH-1:0] Multiplicador;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  int checks   = 0;
  int failures = 0;
  int done_pulses = 0;

  mult_booth #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .Multiplicando(Multiplicando),
    .Multiplicador(Multiplicador),
    .busy         (busy),
    .done         (done),
    .Hi           (Hi),
    .Lo           (Lo)
  );

  always #5 clk = ~clk;

  // Reference model: an accepted start yields the signed product WIDTH edges later.
  logic [63:0] exp_prod;
  logic [63:0] pend_prod;
  logic        exp_busy;
  logic        exp_done;
  int          remaining;
  logic        model_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      exp_prod  = '0;
      exp_busy  = 1'b0;
      exp_done  = 1'b0;
      remaining = 0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      exp_done = 1'b0;
      if (remaining > 0) begin
        remaining = remaining - 1;
        if (remaining == 0) begin
          exp_prod = pend_prod;
          exp_done = 1'b1;
          exp_busy = 1'b0;
        end
      end else if (start) begin
        pend_prod = 64'(longint'($signed(Multiplicando)) * longint'($signed(Multiplicador)));
        remaining = WIDTH;
        exp_busy  = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Every-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("cyc_hi",   64'(Hi),   64'(exp_prod[63:32]));
      checkOutput("cyc_lo",   64'(Lo),   64'(exp_prod[31:0]));
      checkOutput("cyc_busy", 64'(busy), 64'(exp_busy));
      checkOutput("cyc_done", 64'(done), 64'(exp_done));
      if (done) done_pulses++;
    end
  end

  // Called at a falling edge; start is sampled on the next rising edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    start         = 1'b1;
    Multiplicando = a;
    Multiplicador = b;
    @(negedge clk);
    start         = 1'b0;
    Multiplicando = $urandom;
    Multiplicador = $urandom;
  endtask

  task automatic waitDone(input string name, output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout: got no done expected done within 40 cycles", name);
    end
  endtask

  task automatic runOp(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi_exp, input logic [31:0] lo_exp);
    int lat;
    applyStimulus(a, b);
    waitDone(name, lat);
    checkOutput({name, "_lat"}, 64'(lat), 64'(32));
    checkOutput({name, "_hi"},  64'(Hi),  64'(hi_exp));
    checkOutput({name, "_lo"},  64'(Lo),  64'(lo_exp));
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int pulses_before;
    logic [31:0] ra, rb;
    logic [63:0] rp;

    reset = 1'b1;
    start = 1'b0;
    Multiplicando = '0;
    Multiplicador = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_hi",   64'(Hi),   64'(0));
    checkOutput("rst_lo",   64'(Lo),   64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
    checkOutput("rst_done", 64'(done), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // Reset together with start: reset wins, nothing begins.
    reset = 1'b1;
    applyStimulus(32'd9, 32'd9);
    reset = 1'b0;
    checkOutput("rststart_busy", 64'(busy), 64'(0));
    @(negedge clk);

    runOp("mul_7x6",   32'h00000007, 32'h00000006, 32'h00000000, 32'h0000002A);
    runOp("mul_m7x6",  32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFD6);
    runOp("mul_6xm7",  32'h00000006, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFD6);
    runOp("mul_minmin",32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    runOp("mul_maxmax",32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001);
    runOp("mul_minx1", 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000);

    // Reset mid-operation: abort with no done pulse.
    applyStimulus(32'h12345678, 32'h9ABCDEF0);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_hi",   64'(Hi),   64'(0));
    checkOutput("abort_lo",   64'(Lo),   64'(0));
    checkOutput("abort_busy", 64'(busy), 64'(0));
    pulses_before = done_pulses;
    repeat (40) @(negedge clk);
    checkOutput("abort_nodone", 64'(done_pulses - pulses_before), 64'(0));
    runOp("mul_3x5", 32'd3, 32'd5, 32'h00000000, 32'h0000000F);
    runOp("mul_7x6b", 32'd7, 32'd6, 32'h00000000, 32'h0000002A);

    // Start while busy is ignored; Hi/Lo hold the previous product meanwhile.
    pulses_before = done_pulses;
    applyStimulus(32'd3, 32'd5);
    repeat (3) @(negedge clk);
    applyStimulus(32'd100, 32'd100);
    checkOutput("hold_lo", 64'(Lo), 64'(32'h0000002A));
    checkOutput("hold_hi", 64'(Hi), 64'(0));
    waitDone("busy_start", lat);
    checkOutput("busy_start_lo", 64'(Lo), 64'(32'h0000000F));
    repeat (40) @(negedge clk);
    checkOutput("busy_start_pulses", 64'(done_pulses - pulses_before), 64'(1));

    // Back-to-back: new start issued in the done cycle of the prior op.
    applyStimulus(32'd7, 32'd6);
    waitDone("b2b_first", lat);
    checkOutput("b2b_prior_lo",   64'(Lo),   64'(32'h0000002A));
    checkOutput("b2b_prior_done", 64'(done), 64'(1));
    applyStimulus(32'd2, 32'hFFFFFFFD);
    waitDone("b2b_second", lat);
    checkOutput("b2b_lat", 64'(lat), 64'(32));
    checkOutput("b2b_hi",  64'(Hi),  64'(32'hFFFFFFFF));
    checkOutput("b2b_lo",  64'(Lo),  64'(32'hFFFFFFFA));
    @(negedge clk);

    // Randomized pairs against the plain 64-bit signed product.
    for (int n = 0; n < 1000; n++) begin
      ra = $urandom;
      rb = $urandom;
      if (n % 50 == 0) ra = 32'h80000000;
      if (n % 70 == 0) rb = 32'hFFFFFFFF;
      rp = 64'(longint'($signed(ra)) * longint'($signed(rb)));
      applyStimulus(ra, rb);
      waitDone("rand", lat);
      checkOutput("rand_prod", {Hi, Lo}, rp);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_booth.md
Name: mult_booth

Overview:
- Sequential signed 32x32 multiplier for the multicycle datapath's MULT instruction; the counterpart of the sequential divider.
- Uses radix-2 Booth recoding with one iteration per clock.
- Writes the 64-bit product into Hi (upper 32 bits) and Lo (lower 32 bits).
- The control unit pulses start, then waits for done before reading Hi/Lo.

Parameters:
- WIDTH, 32, operand width; Hi/Lo are WIDTH bits each; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high global reset.
- start  input  1  one-cycle request; operands are sampled on the same edge.
- Multiplicando  input  WIDTH  signed multiplicand (two's complement).
- Multiplicador  input  WIDTH  signed multiplier (two's complement).
- busy  output  1  high while iterations are in progress.
- done  output  1  one-cycle pulse; Hi/Lo are valid from this cycle.
- Hi  output  WIDTH  product[2*WIDTH-1:WIDTH].
- Lo  output  WIDTH  product[WIDTH-1:0].

Behaviour:
- Reset is synchronous and active-high; the clock port is clk and the reset port is reset.
- Reset values: Hi=0, Lo=0, busy=0, done=0, state=IDLE, counter=0, internal registers cleared.
- Internal registers:
  - M: WIDTH+1 bits, sign-extended multiplicand.
  - A: WIDTH+1-bit accumulator.
  - Q: WIDTH bits, multiplier.
  - q_1: 1-bit Booth history.
  - cnt: 6 bits.
- The extra accumulator bit is mandatory so that M = -2^31 does not overflow on A-M.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at edge N: M<=sext(Multiplicando), A<=0, Q<=Multiplicador, q_1<=0, cnt<=WIDTH, busy<=1, go to RUN.
  - Otherwise hold.
- RUN (each edge):
  - Select on {Q[0],q_1}: 01 -> A'=A+M; 10 -> A'=A-M; 00/11 -> A'=A.
  - Then arithmetic shift right of {A',Q,q_1} by one bit; the A MSB is replicated.
  - cnt<=cnt-1.
  - On the step where cnt==1 (the last step), also:
    - Hi<=A_shifted[WIDTH-1:0], Lo<=Q_shifted.
    - done<=1, busy<=0, go to DONE.
- Latency: start sampled at edge N; steps execute at edges N+1..N+WIDTH; done=1 and Hi/Lo valid after edge N+WIDTH (N+32 by default).
- DONE:
  - done high for exactly one cycle; next edge done<=0.
  - If start=1 on that edge, load new operands and go to RUN (back-to-back allowed, same latency).
  - Otherwise go to IDLE.
- Hi/Lo:
  - Change only at completion or reset.
  - Hold the last result indefinitely, including during a subsequent operation until it completes.
- start while busy=1 (RUN): ignored; operands are not resampled and the operation continues unaffected.
- reset mid-operation: aborts on that edge; all outputs return to reset values; no done pulse.
- reset and start on the same edge: reset wins; the block stays in IDLE.
- Result is the exact two's-complement 64-bit product for all operand pairs, including -2^31 x -2^31; no overflow flag.
- Operand inputs may change freely after the start edge.

Test Plan:
- 7 x 6: start with Multiplicando=0x00000007, Multiplicador=0x00000006 -> done exactly 32 cycles after the start edge; Hi=0x00000000, Lo=0x0000002A; busy high for cycles 1..32 after start.
- Mixed signs, -7 x 6: Multiplicando=0xFFFFFFF9, Multiplicador=0x00000006 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFD6. Also 6 x -7 gives the same result.
- Extremes:
  - 0x80000000 x 0x80000000 -> Hi=0x40000000, Lo=0x00000000.
  - 0x7FFFFFFF x 0x7FFFFFFF -> Hi=0x3FFFFFFF, Lo=0x00000001.
  - 0x80000000 x 0x00000001 -> Hi=0xFFFFFFFF, Lo=0x80000000.
- Reset mid-operation:
  - Start 0x12345678 x 0x9ABCDEF0; assert reset at cycle 10 -> next edge Hi=Lo=0, busy=0, done never pulses.
  - Then start 3 x 5 -> Hi=0, Lo=0x0000000F.
- Start while busy:
  - Start 3 x 5; pulse start with 100 x 100 at cycle 5 -> only one done, Hi=0, Lo=0x0000000F.
  - Hi/Lo hold their prior values until that done.
- Back-to-back:
  - Assert start with 2 x -3 in the cycle done is high for a prior op.
  - Required: the prior result is visible in that cycle; new done follows 32 cycles later with Hi=0xFFFFFFFF, Lo=0xFFFFFFFA.
  - Randomized 1000-pair check against the 64-bit signed reference product.
